// File: rtl/fetch_deco_queue.sv
// fetch_deco_queue: DEPTH-entry fetch-to-decode buffer with valid/ready handshakes,
// synchronous flush and combinational field split of the head instruction.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   Reset      synchronous active-high reset (priority over flush)
//   flush      drops all buffered entries and the same-cycle input/pop
//   in_valid   fetch presents pc_in/Instr
//   in_ready   buffer not full (registered count only)
//   pc_in      PC of the incoming instruction
//   Instr      incoming instruction word
//   out_valid  head entry present (registered count only)
//   out_ready  decode consumes the head entry
//   pc         head PC, 0 when empty
//   Opcode     head opcode field, 0 when empty
//   r0/r1/r2   head register fields, 0 when empty
//   Imm        head immediate extended to PC_W, 0 when empty
//   count      occupied entries
//
// Build option: define FETCH_DECO_IMM_SEXT_EN to sign-extend Imm; otherwise it is
// zero-extended.
module fetch_deco_queue #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int OP_W    = 5,
    parameter int REG_W   = 7,
    parameter int IMM_W   = 19,
    parameter int DEPTH   = 2
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            pc_in,
    input  logic [INSTR_W-1:0]         Instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            pc,
    output logic [OP_W-1:0]            Opcode,
    output logic [REG_W-1:0]           r0,
    output logic [REG_W-1:0]           r1,
    output logic [REG_W-1:0]           r2,
    output logic [PC_W-1:0]            Imm,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (OP_W + 3 * REG_W > INSTR_W) begin : g_bad_fields
        $error("fetch_deco_queue: OP_W + 3*REG_W exceeds INSTR_W");
    end
    if (IMM_W > PC_W) begin : g_bad_imm
        $error("fetch_deco_queue: IMM_W exceeds PC_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_deco_queue: DEPTH must be a power of two >= 2");
    end

    logic [PC_W-1:0]    pc_mem  [DEPTH];
    logic [INSTR_W-1:0] ins_mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push;
    logic               pop;
    logic [INSTR_W-1:0] head_ins;
    logic [IMM_W-1:0]   imm_raw;

    assign in_ready  = count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (Reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage is not reset; emptiness is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]  <= pc_in;
            ins_mem[wr_ptr] <= Instr;
        end
    end

    // Outputs are forced to zero when empty so decode never sees stale data.
    always_comb begin
        pc       = out_valid ? pc_mem[rd_ptr] : '0;
        head_ins = out_valid ? ins_mem[rd_ptr] : '0;
        Opcode   = head_ins[INSTR_W-1 -: OP_W];
        r0       = head_ins[INSTR_W-OP_W-1 -: REG_W];
        r1       = head_ins[INSTR_W-OP_W-REG_W-1 -: REG_W];
        r2       = head_ins[INSTR_W-OP_W-2*REG_W-1 -: REG_W];
        imm_raw  = head_ins[IMM_W-1:0];
`ifdef FETCH_DECO_IMM_SEXT_EN
        Imm      = PC_W'($signed(imm_raw));
`else
        Imm      = PC_W'(imm_raw);
`endif
    end
endmodule

// File: tb/tb_fetch_deco_queue.sv
// tb_fetch_deco_queue: directed self-checking bench for fetch_deco_queue (DEPTH=2).
module tb_fetch_deco_queue;
    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] pc_in = '0;
    logic [31:0] Instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] pc;
    logic [4:0]  Opcode;
    logic [6:0]  r0, r1, r2;
    logic [31:0] Imm;
    logic [1:0]  count;
    int          tests = 0;
    int          fails = 0;

    fetch_deco_queue dut (
        .clk(clk), .Reset(Reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .Instr(Instr), .out_valid(out_valid), .out_ready(out_ready),
        .pc(pc), .Opcode(Opcode), .r0(r0), .r1(r1), .r2(r2), .Imm(Imm), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_opcode"}, 32'(Opcode), 32'd0);
        chk({tag, "_r0"}, 32'(r0), 32'd0);
        chk({tag, "_imm"}, Imm, 32'd0);
    endtask

`ifdef FETCH_DECO_IMM_SEXT_EN
    localparam logic [31:0] IMM_EXP = 32'hFFFF_3FC0;
`else
    localparam logic [31:0] IMM_EXP = 32'h0007_3FC0;
`endif

    initial begin
        step();
        step();
        Reset = 1'b0;
        chk_empty("reset");

        in_valid = 1'b1; pc_in = 32'h100; Instr = 32'h8A5F_3FC0;
        step();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_pc", pc, 32'h100);
        chk("single_opcode", 32'(Opcode), 32'h11);
        chk("single_r0", 32'(r0), 32'h25);
        chk("single_r1", 32'(r1), 32'h79);
        chk("single_r2", 32'(r2), 32'h7F);
        chk("single_imm", Imm, IMM_EXP);
        chk("single_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_empty("single_pop");

        in_valid = 1'b1; pc_in = 32'h10; Instr = 32'h1000_0000;
        step();
        chk("fill1_count", 32'(count), 32'd1);
        pc_in = 32'h14; Instr = 32'h2000_0000;
        step();
        pc_in = 32'h18; Instr = 32'h3000_0000;
        chk("full_count", 32'(count), 32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("held_count", 32'(count), 32'd2);
        chk("held_pc", pc, 32'h10);
        out_ready = 1'b1;
        step();
        chk("drain1_count", 32'(count), 32'd1);
        chk("drain1_pc", pc, 32'h14);
        chk("drain1_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("third_count", 32'(count), 32'd1);
        chk("third_pc", pc, 32'h18);
        chk("third_opcode", 32'(Opcode), 32'h06);
        step();
        chk("drain_done_count", 32'(count), 32'd0);

        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc_in = 32'(4 * i);
            Instr = 32'(i) << 27;
            step();
            chk($sformatf("stream%0d_pc", i), pc, 32'(4 * i));
            chk($sformatf("stream%0d_opcode", i), 32'(Opcode), 32'(i));
            chk($sformatf("stream%0d_count", i), 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_count", 32'(count), 32'd0);

        out_ready = 1'b0; in_valid = 1'b1;
        pc_in = 32'h300; Instr = 32'hFFFF_FFFF;
        step();
        pc_in = 32'h304;
        step();
        chk("preflush_count", 32'(count), 32'd2);
        flush = 1'b1; out_ready = 1'b1; pc_in = 32'h308;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk_empty("flush");
        step();
        chk_empty("flush_after");

        out_ready = 1'b0; in_valid = 1'b1;
        pc_in = 32'h400; Instr = 32'hFFFF_FFFF;
        step();
        pc_in = 32'h404;
        step();
        chk("prereset_count", 32'(count), 32'd2);
        Reset = 1'b1; flush = 1'b1; pc_in = 32'h408;
        step();
        Reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk_empty("reset_flush");
        in_valid = 1'b1; pc_in = 32'h200; Instr = 32'h0;
        step();
        in_valid = 1'b0;
        chk("post_reset_count", 32'(count), 32'd1);
        chk("post_reset_pc", pc, 32'h200);
        out_ready = 1'b1;
        step();
        chk_empty("post_reset_alone");

        step();
        step();
        chk_empty("underflow");
        chk("underflow_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
